// File: rtl/bcd_event_counter_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared BCD digit type and terminal-count helpers for the counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  function automatic bcd_digit_t max_ones(input int unsigned max_count);
    return bcd_digit_t'(max_count % 10);
  endfunction

  function automatic bcd_digit_t max_tens(input int unsigned max_count);
    return bcd_digit_t'(max_count / 10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_event_counter_if.sv
// ============================================================================
// Module : bcd_event_counter_if
// Brief  : Control inputs and display-digit outputs of the BCD event counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_event_counter_if;
  import bcd_pkg::*;

  logic       i_event;
  logic       i_en;
  logic       i_dir;
  logic       i_clr;
  bcd_digit_t o_ones;
  bcd_digit_t o_tens;
  logic       o_wrap;
  logic       o_at_max;

  modport master (
    output i_event, i_en, i_dir, i_clr,
    input  o_ones, o_tens, o_wrap, o_at_max
  );

  modport slave (
    input  i_event, i_en, i_dir, i_clr,
    output o_ones, o_tens, o_wrap, o_at_max
  );

endinterface

`default_nettype wire

// File: rtl/bcd_event_counter_digit.sv
// ============================================================================
// Module : bcd_digit
// Brief  : One registered BCD digit with load, increment and decrement.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_load,
  input  bcd_digit_t i_load_val,
  output bcd_digit_t o_value,
  output bcd_digit_t o_next,
  output logic       o_carry,
  output logic       o_borrow
);

  bcd_digit_t value_q;
  bcd_digit_t value_d;

  always_comb begin
    value_d = value_q;
    if (i_load) begin
      value_d = i_load_val;
    end else if (i_inc) begin
      value_d = (value_q == BCD_MAX_DIGIT) ? 4'd0 : value_q + 4'd1;
    end else if (i_dec) begin
      value_d = (value_q == 4'd0) ? BCD_MAX_DIGIT : value_q - 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign o_value  = value_q;
  assign o_next   = value_d;
  assign o_carry  = i_inc & (value_q == BCD_MAX_DIGIT);
  assign o_borrow = i_dec & (value_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/bcd_event_counter.sv
// ============================================================================
// Module : bcd_event_counter
// Brief  : Two-digit up/down BCD counter of synchronized event-line rising
//          edges. Define BCD_CNT_SATURATE_EN to saturate instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_event_counter
  import bcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COUNT   = 99
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  bcd_event_counter_if.slave   bus
);

  localparam bcd_digit_t c_max_ones = max_ones(MAX_COUNT);
  localparam bcd_digit_t c_max_tens = max_tens(MAX_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   edge_q;
  logic                   armed_q;
  logic                   wrap_q;
  logic                   at_max_q;

  logic w_sync_out;
  logic w_flushed;
  logic w_step;

  assign w_sync_out = sync_q[SYNC_STAGES-1];
  assign w_flushed  = flush_q[SYNC_STAGES-1];

  // Only arm once a flushed synchronizer has shown the line low, so a line
  // already high at reset release needs a genuine new edge before counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      flush_q <= '0;
      edge_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.i_event};
      flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      edge_q  <= w_sync_out;
      if (w_flushed && !w_sync_out) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign w_step = w_sync_out & ~edge_q & armed_q & bus.i_en;

  logic       w_up;
  logic       w_dn;
  logic       w_at_zero;
  logic       w_load;
  bcd_digit_t w_load_ones;
  bcd_digit_t w_load_tens;
  logic       w_ones_inc;
  logic       w_ones_dec;
  logic       w_wrap_d;
  logic       w_ones_carry;
  logic       w_ones_borrow;
  logic       unused_tens_carry;
  logic       unused_tens_borrow;
  bcd_digit_t w_ones_val;
  bcd_digit_t w_tens_val;
  bcd_digit_t w_ones_next;
  bcd_digit_t w_tens_next;

  assign w_up      = w_step &  bus.i_dir & ~bus.i_clr;
  assign w_dn      = w_step & ~bus.i_dir & ~bus.i_clr;
  assign w_at_zero = (w_ones_val == 4'd0) && (w_tens_val == 4'd0);

`ifdef BCD_CNT_SATURATE_EN
  assign w_load      = bus.i_clr;
  assign w_load_ones = 4'd0;
  assign w_load_tens = 4'd0;
  assign w_ones_inc  = w_up & ~at_max_q;
  assign w_ones_dec  = w_dn & ~w_at_zero;
  assign w_wrap_d    = 1'b0;
`else
  logic w_term_up;
  logic w_term_dn;

  assign w_term_up   = w_up & at_max_q;
  assign w_term_dn   = w_dn & w_at_zero;
  assign w_load      = bus.i_clr | w_term_up | w_term_dn;
  assign w_load_ones = w_term_dn ? c_max_ones : 4'd0;
  assign w_load_tens = w_term_dn ? c_max_tens : 4'd0;
  assign w_ones_inc  = w_up;
  assign w_ones_dec  = w_dn;
  assign w_wrap_d    = w_term_up | w_term_dn;
`endif

  bcd_digit u_ones (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_inc      (w_ones_inc),
    .i_dec      (w_ones_dec),
    .i_load     (w_load),
    .i_load_val (w_load_ones),
    .o_value    (w_ones_val),
    .o_next     (w_ones_next),
    .o_carry    (w_ones_carry),
    .o_borrow   (w_ones_borrow)
  );

  bcd_digit u_tens (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_inc      (w_ones_carry & ~w_load),
    .i_dec      (w_ones_borrow & ~w_load),
    .i_load     (w_load),
    .i_load_val (w_load_tens),
    .o_value    (w_tens_val),
    .o_next     (w_tens_next),
    .o_carry    (unused_tens_carry),
    .o_borrow   (unused_tens_borrow)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrap_q   <= 1'b0;
      at_max_q <= 1'b0;
    end else begin
      wrap_q   <= w_wrap_d;
      at_max_q <= (w_ones_next == c_max_ones) && (w_tens_next == c_max_tens);
    end
  end

  assign bus.o_ones   = w_ones_val;
  assign bus.o_tens   = w_tens_val;
  assign bus.o_wrap   = wrap_q;
  assign bus.o_at_max = at_max_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_event_counter.sv
// ============================================================================
// Module : tb_bcd_event_counter
// Brief  : Scoreboard bench for two counters (MAX_COUNT 99 and 59).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_event_counter;
  import bcd_pkg::*;

  localparam int SS = 2;
`ifdef BCD_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_event_counter_if bus_a ();
  bcd_event_counter_if bus_b ();

  bcd_event_counter #(.SYNC_STAGES(SS), .MAX_COUNT(99)) u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  bcd_event_counter #(.SYNC_STAGES(SS), .MAX_COUNT(59)) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    bit wrap;
    bit at_max;
    int cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   passed = 0;
  int   mv_a   = 0;
  int   mv_b   = 0;

  task automatic score(input string nm, input bit have, input exp_t e,
                       input logic [3:0] t, input logic [3:0] o,
                       input logic w, input logic m);
    checks++;
    if (!have) begin
      $display("FAIL %s unexpected update: got %0d%0d wrap=%0b at_max=%0b at cyc %0d, none expected",
               nm, t, o, w, m, cyc);
    end else if (t != 4'(e.val / 10) || o != 4'(e.val % 10) || w != e.wrap ||
                 m != e.at_max || cyc != e.cyc) begin
      $display("FAIL %s update: got %0d%0d wrap=%0b at_max=%0b cyc=%0d, required %0d wrap=%0b at_max=%0b cyc=%0d",
               nm, t, o, w, m, cyc, e.val, e.wrap, e.at_max, e.cyc);
    end else begin
      passed++;
    end
  endtask

  logic [7:0] prev_a = '0;
  logic [7:0] prev_b = '0;

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (!rst_n) begin
      prev_a = '0;
    end else begin
      if ({bus_a.o_tens, bus_a.o_ones} != prev_a || bus_a.o_wrap) begin
        have = (q_a.size() > 0);
        e    = '{default: 0};
        if (have) e = q_a.pop_front();
        score("dut99", have, e, bus_a.o_tens, bus_a.o_ones, bus_a.o_wrap, bus_a.o_at_max);
      end
      prev_a = {bus_a.o_tens, bus_a.o_ones};
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (!rst_n) begin
      prev_b = '0;
    end else begin
      if ({bus_b.o_tens, bus_b.o_ones} != prev_b || bus_b.o_wrap) begin
        have = (q_b.size() > 0);
        e    = '{default: 0};
        if (have) e = q_b.pop_front();
        score("dut59", have, e, bus_b.o_tens, bus_b.o_ones, bus_b.o_wrap, bus_b.o_at_max);
      end
      prev_b = {bus_b.o_tens, bus_b.o_ones};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic ev, input logic en,
                       input logic dir, input logic clr);
    if (d == 0) begin
      bus_a.i_event = ev; bus_a.i_en = en; bus_a.i_dir = dir; bus_a.i_clr = clr;
    end else begin
      bus_b.i_event = ev; bus_b.i_en = en; bus_b.i_dir = dir; bus_b.i_clr = clr;
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // One event pulse, SS+2 clocks high then SS+2 low; optional clear on the step cycle.
  task automatic pulse(input int d, input bit dir, input bit en, input bit clr_at_step);
    int mx, v, nv, k;
    bit w;
    mx = (d == 0) ? 99 : 59;
    v  = (d == 0) ? mv_a : mv_b;
    nv = v;
    w  = 1'b0;
    if (clr_at_step)      nv = 0;
    else if (!en)         nv = v;
    else if (dir) begin
      if (v == mx) begin nv = SAT ? v : 0;  w = !SAT; end
      else nv = v + 1;
    end else begin
      if (v == 0)  begin nv = SAT ? 0 : mx; w = !SAT; end
      else nv = v - 1;
    end
    k = cyc;
    drive(d, 1'b1, en, dir, 1'b0);
    if (nv != v || w) push(d, '{val: nv, wrap: w, at_max: (nv == mx), cyc: k + SS + 1});
    if (clr_at_step) begin
      tick(SS);
      drive(d, 1'b1, en, dir, 1'b1);
      tick(1);
      drive(d, 1'b1, en, dir, 1'b0);
      tick(1);
    end else begin
      tick(SS + 2);
    end
    drive(d, 1'b0, 1'b1, dir, 1'b0);
    tick(SS + 2);
    if (d == 0) mv_a = nv;
    else        mv_b = nv;
  endtask

  task automatic do_clr(input int d);
    int v;
    v = (d == 0) ? mv_a : mv_b;
    if (v != 0) push(d, '{val: 0, wrap: 1'b0, at_max: 1'b0, cyc: cyc + 1});
    drive(d, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    drive(d, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    if (d == 0) mv_a = 0;
    else        mv_b = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1, 1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      drive(0, logic'(i % 2), 1'b1, 1'b1, 1'b0);
      drive(1, logic'(i % 2), 1'b1, 1'b1, 1'b0);
      tick(1);
    end
    @(negedge clk);
    checks++;
    if ({bus_a.o_tens, bus_a.o_ones, bus_a.o_wrap, bus_a.o_at_max} != 10'd0)
      $display("FAIL reset99: got %0d%0d wrap=%0b at_max=%0b, required 00 0 0",
               bus_a.o_tens, bus_a.o_ones, bus_a.o_wrap, bus_a.o_at_max);
    else passed++;
    checks++;
    if ({bus_b.o_tens, bus_b.o_ones, bus_b.o_wrap, bus_b.o_at_max} != 10'd0)
      $display("FAIL reset59: got %0d%0d wrap=%0b at_max=%0b, required 00 0 0",
               bus_b.o_tens, bus_b.o_ones, bus_b.o_wrap, bus_b.o_at_max);
    else passed++;

    // Release with the event line already high: no count until a fresh edge.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick(10);
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(SS + 2);

    for (int i = 0; i < 12; i++) pulse(0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 87; i++) pulse(0, 1'b1, 1'b1, 1'b0);
    pulse(0, 1'b1, 1'b1, 1'b0);
    do_clr(0);
    pulse(0, 1'b0, 1'b1, 1'b0);
    do_clr(0);
    for (int i = 0; i < 10; i++) pulse(0, 1'b1, 1'b1, 1'b0);
    pulse(0, 1'b0, 1'b1, 1'b0);
    pulse(0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) pulse(0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pulse(0, 1'b1, 1'b0, 1'b0);
    pulse(0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) pulse(1, 1'b1, 1'b1, 1'b0);
    // Sub-clock glitch that no clock edge samples.
    #2 bus_b.i_event = 1'b1;
    #2 bus_b.i_event = 1'b0;
    tick(2 * SS + 4);
    pulse(1, 1'b0, 1'b1, 1'b0);

    tick(SS + 4);
    checks++;
    if (q_a.size() != 0) $display("FAIL drain99: got %0d pending updates, required 0", q_a.size());
    else passed++;
    checks++;
    if (q_b.size() != 0) $display("FAIL drain59: got %0d pending updates, required 0", q_b.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
